modul_s_pietoni: RTL
====================

# modul_s_pietoni

South-approach traffic-light controller with a pedestrian crossing. It is the stage directly downstream of the north-approach controller in the intersection token ring. It waits for the north→south handoff, runs a yellow-then-green car phase, optionally runs a pedestrian phase on demand, then passes the token to the west stage. A maintenance input overrides everything with flashing yellow.

## Interface
- `SEC`, 24'd10000000 — clk cycles per one-second tick; legal 1..2^24-1
- `T_GALBEN`, 8'd2 — pre-green yellow duration, seconds
- `T_VERDE`, 8'd26 — car green duration, seconds
- `T_PIETON`, 8'd10 — pedestrian steady-green duration, seconds
- `T_CLIPIRE`, 8'd4 — pedestrian flashing-green duration, seconds; all durations legal 1..255
- `clk` input 1 — single system clock
- `reset` input 1 — asynchronous, active-low; one clock; reset is asynchronous and active-low
- `intretinere` input 1 — maintenance mode, level
- `Continuare_n_s` input 1 — handoff from north stage, acted on at rising edge
- `buton_pieton` input 1 — pedestrian request button, level, synchronous to clk
- `Continuare_s_v` output 1 — handoff to west stage, one-cycle pulse
- `Verde_auto_S`, `Galben_auto_S`, `Rosu_auto_S` output 1 each — car lights
- `Verde_pieton_S`, `Rosu_pieton_S` output 1 each — pedestrian lights

## Operation
- States: IDLE, GALBEN, VERDE, PIETON, CLIPIRE, DONE, MENT.
- Lights are Moore-decoded from the state register:
  - IDLE/PIETON/CLIPIRE/DONE: car red.
  - GALBEN: car yellow. VERDE: car green.
  - Pedestrian red everywhere except PIETON (steady green) and CLIPIRE (green = blink flop).
  - MENT: car yellow = blink flop; all other lights 0.
- Reset values: state IDLE; car red=1, yellow/green=0; ped red=1, ped green=0; `Continuare_s_v`=0; request latch, blink flop, edge register, prescaler and phase counter all 0.
- Handoff detection: `Continuare_n_s` is registered each clk; a rising edge is prev=0, cur=1.
- Transitions:
  - IDLE→GALBEN on a handoff edge. Edges in any other state are ignored and not queued.
  - GALBEN→VERDE after T_GALBEN ticks.
  - VERDE→PIETON after T_VERDE ticks if the request latch is 1, else VERDE→DONE.
  - PIETON→CLIPIRE after T_PIETON ticks.
  - CLIPIRE→DONE after T_CLIPIRE ticks.
  - DONE→IDLE unconditionally after 1 cycle; `Continuare_s_v`=1 only in DONE.
- Request latch:
  - Set on a `buton_pieton` rising edge in any non-MENT state.
  - Cleared on entry to PIETON; set wins if both occur in the same cycle.
  - A press during PIETON/CLIPIRE is kept for the next round.
- Maintenance:
  - `intretinere`=1 forces MENT from any state on the next edge, with priority over every other transition. Request latch cleared.
  - In MENT the blink flop toggles every tick.
  - On deassert, MENT→IDLE. Blink flop, phase counter and prescaler cleared; a token held at maintenance entry is lost.
- Widths: phase counter 8 bits, compared against duration-1; prescaler 24 bits.

## Timing
- Prescaler and phase counter restart at 0 on every state change. A phase of D seconds therefore lasts exactly D·SEC cycles.
- Tick occurs when prescaler = SEC-1; the prescaler then wraps to 0.
- Handoff edge sampled in cycle n → GALBEN visible in cycle n+1; lights change the same cycle as state.
- CLIPIRE blink: toggles per tick, starting at 1 on state entry.
- Reset mid-phase: immediate return to reset values, no handoff pulse.

## Structure
- Package `semafor_pkg`:
  - State enum/localparams for all seven states.
  - Default durations and SEC.
  - Shared with the other approach controllers.
- Sub-module `prescaler_sec`:
  - Inputs: clk, reset, synchronous clear.
  - Output: 1-cycle tick every SEC cycles.
- FSM, request latch, edge detect and light decode stay in the top.

## Test plan
Parameters for all scenarios: SEC=4, defaults otherwise.
- Reset, then idle 50 cycles → car red=1, ped red=1, `Continuare_s_v` never 1.
- Handoff edge, no button → GALBEN 8 cycles, VERDE 104 cycles, DONE one-cycle `Continuare_s_v` pulse, then IDLE.
- Button pulsed during VERDE → after VERDE: PIETON 40 cycles (ped green steady), CLIPIRE 16 cycles with ped green toggling every 4 cycles, then DONE pulse; latch 0 afterwards.
- Second handoff edge during VERDE and button pressed during PIETON → extra edge ignored; latch reads 1 after DONE.
- `intretinere`=1 mid-VERDE → MENT next cycle, car yellow toggles every 4 cycles, others 0. Deassert → IDLE with all counters 0.
- `reset` asserted mid-PIETON → all outputs at reset values within the same cycle, asynchronously.

Source files
------------

// File: rtl/semafor_pkg.sv
// rtl/semafor_pkg.sv - shared state encoding and default timings for the approach controllers
package semafor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GALBEN  = 3'd1,
    ST_VERDE   = 3'd2,
    ST_PIETON  = 3'd3,
    ST_CLIPIRE = 3'd4,
    ST_DONE    = 3'd5,
    ST_MENT    = 3'd6
  } stare_t;

  localparam logic [23:0] SEC_DEFAULT       = 24'd10000000;
  localparam logic [7:0]  T_GALBEN_DEFAULT  = 8'd2;
  localparam logic [7:0]  T_VERDE_DEFAULT   = 8'd26;
  localparam logic [7:0]  T_PIETON_DEFAULT  = 8'd10;
  localparam logic [7:0]  T_CLIPIRE_DEFAULT = 8'd4;

endpackage

// File: rtl/prescaler_sec.sv
// rtl/prescaler_sec.sv - one-second tick generator with synchronous restart
module prescaler_sec #(
  parameter logic [23:0] SEC = semafor_pkg::SEC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [23:0] cnt_q;

  // Tick is decoded from the count alone so callers may use it to build clr
  assign tick = (cnt_q == (SEC - 24'd1));

  // Count cycles within the current second; restart on clear or wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 24'd0;
    end else if (clr || tick) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_q + 24'd1;
    end
  end

endmodule

// File: rtl/modul_s_pietoni.sv
// rtl/modul_s_pietoni.sv - south approach light controller with pedestrian phase
module modul_s_pietoni import semafor_pkg::*; #(
  parameter logic [23:0] SEC       = SEC_DEFAULT,
  parameter logic [7:0]  T_GALBEN  = T_GALBEN_DEFAULT,
  parameter logic [7:0]  T_VERDE   = T_VERDE_DEFAULT,
  parameter logic [7:0]  T_PIETON  = T_PIETON_DEFAULT,
  parameter logic [7:0]  T_CLIPIRE = T_CLIPIRE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic intretinere,
  input  logic Continuare_n_s,
  input  logic buton_pieton,
  output logic Continuare_s_v,
  output logic Verde_auto_S,
  output logic Galben_auto_S,
  output logic Rosu_auto_S,
  output logic Verde_pieton_S,
  output logic Rosu_pieton_S
);

  stare_t     state_q, state_d;
  logic       cont_prev_q;
  logic       buton_prev_q;
  logic       cerere_q;
  logic       blink_q;
  logic [7:0] faza_q;
  logic       tick;
  logic       schimb;
  logic       cont_edge;
  logic       buton_edge;

  assign cont_edge  = Continuare_n_s & ~cont_prev_q;
  assign buton_edge = buton_pieton & ~buton_prev_q;
  assign schimb     = (state_d != state_q);

  // Every state change restarts the second so each phase lasts whole seconds
  prescaler_sec #(.SEC(SEC)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (schimb),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: maintenance overrides everything, otherwise timed phases
  always_comb begin
    state_d = state_q;
    if (intretinere) begin
      state_d = ST_MENT;
    end else begin
      case (state_q)
        ST_IDLE:    if (cont_edge) state_d = ST_GALBEN;
        ST_GALBEN:  if (tick && faza_q == T_GALBEN - 8'd1) state_d = ST_VERDE;
        ST_VERDE:   if (tick && faza_q == T_VERDE - 8'd1)
                      state_d = cerere_q ? ST_PIETON : ST_DONE;
        ST_PIETON:  if (tick && faza_q == T_PIETON - 8'd1) state_d = ST_CLIPIRE;
        ST_CLIPIRE: if (tick && faza_q == T_CLIPIRE - 8'd1) state_d = ST_DONE;
        ST_DONE:    state_d = ST_IDLE;
        ST_MENT:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Input edge registers for the handoff and the pedestrian button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cont_prev_q  <= 1'b0;
      buton_prev_q <= 1'b0;
    end else begin
      cont_prev_q  <= Continuare_n_s;
      buton_prev_q <= buton_pieton;
    end
  end

  // Seconds elapsed in the current phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      faza_q <= 8'd0;
    else if (schimb) faza_q <= 8'd0;
    else if (tick)   faza_q <= faza_q + 8'd1;
  end

  // Blink flop: starts lit on CLIPIRE entry, dark elsewhere, toggles per second
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_q <= 1'b0;
    end else if (schimb) begin
      blink_q <= (state_d == ST_CLIPIRE);
    end else if (tick && (state_q == ST_MENT || state_q == ST_CLIPIRE)) begin
      blink_q <= ~blink_q;
    end
  end

  // Pedestrian request: maintenance clears, a new press beats the PIETON-entry clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cerere_q <= 1'b0;
    end else if (state_d == ST_MENT) begin
      cerere_q <= 1'b0;
    end else if (buton_edge && state_q != ST_MENT) begin
      cerere_q <= 1'b1;
    end else if (schimb && state_d == ST_PIETON) begin
      cerere_q <= 1'b0;
    end
  end

  // Moore light decode from the state register
  always_comb begin
    Continuare_s_v = 1'b0;
    Verde_auto_S   = 1'b0;
    Galben_auto_S  = 1'b0;
    Rosu_auto_S    = 1'b0;
    Verde_pieton_S = 1'b0;
    Rosu_pieton_S  = 1'b1;
    case (state_q)
      ST_IDLE:    Rosu_auto_S = 1'b1;
      ST_GALBEN:  Galben_auto_S = 1'b1;
      ST_VERDE:   Verde_auto_S = 1'b1;
      ST_PIETON: begin
        Rosu_auto_S    = 1'b1;
        Verde_pieton_S = 1'b1;
        Rosu_pieton_S  = 1'b0;
      end
      ST_CLIPIRE: begin
        Rosu_auto_S    = 1'b1;
        Verde_pieton_S = blink_q;
        Rosu_pieton_S  = 1'b0;
      end
      ST_DONE: begin
        Rosu_auto_S    = 1'b1;
        Continuare_s_v = 1'b1;
      end
      ST_MENT: begin
        Galben_auto_S = blink_q;
        Rosu_pieton_S = 1'b0;
      end
      default:    Rosu_auto_S = 1'b1;
    endcase
  end

endmodule
